// File: rtl/aexm_dcache_pkg.sv
// Shared types and sizing for the AEXM data-cache responder.
package aexm_dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOK,
    RDMISS,
    WRTHRU,
    REPLAY
  } dcState_t;

  localparam int IDX_W_DEFAULT = 8;

  // Tag covers the word address above the index field.
  function automatic int tagWidth(input int idxW);
    return 30 - idxW;
  endfunction

  localparam int TAG_W_DEFAULT = tagWidth(IDX_W_DEFAULT);

endpackage

// File: rtl/aexm_dcache_if.sv
// Core-side dcache port and backing-memory port of the AEXM data cache.
interface aexm_dcache_if;
  logic [31:0] aexm_dcache_precycle_addr;
  logic        aexm_dcache_precycle_enable;
  logic [31:0] aexm_dcache_cycle_addr;
  logic        aexm_dcache_cycle_we;
  logic [31:0] aexm_dcache_datao;
  logic [31:0] aexm_dcache_datai;
  logic        aexm_dcache_cache_busy_n;

  modport master (
    output aexm_dcache_precycle_addr, aexm_dcache_precycle_enable,
           aexm_dcache_cycle_addr, aexm_dcache_cycle_we, aexm_dcache_datao,
    input  aexm_dcache_datai, aexm_dcache_cache_busy_n
  );

  modport slave (
    input  aexm_dcache_precycle_addr, aexm_dcache_precycle_enable,
           aexm_dcache_cycle_addr, aexm_dcache_cycle_we, aexm_dcache_datao,
    output aexm_dcache_datai, aexm_dcache_cache_busy_n
  );
endinterface

interface aexm_dcache_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/aexm_dcache_ram.sv
// Direct-mapped {tag, data} line store: one synchronous read port, one write port.
module aexm_dcache_ram #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 22
) (
  input  logic             gclk,
  input  logic             rdEn,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [TAG_W-1:0] rdTag,
  output logic [31:0]      rdData,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [TAG_W-1:0] wrTag,
  input  logic [31:0]      wrData
);

  logic [TAG_W+31:0] lineMem [0:(1<<IDX_W)-1];
  logic [TAG_W+31:0] rdLineReg;

  // Writes only occur while the core is stalled, so no read/write bypass is needed.
  always_ff @(posedge gclk) begin
    if (wrEn) begin
      lineMem[wrIdx] <= {wrTag, wrData};
    end
    if (rdEn) begin
      rdLineReg <= lineMem[rdIdx];
    end
  end

  assign {rdTag, rdData} = rdLineReg;

endmodule

// File: rtl/aexm_dcache_resp.sv
// AEXM dcache responder: direct-mapped read cache with write-through stores.
// Define AEXM_DCACHE_WRITE_ALLOC_EN to allocate lines on store misses.
module aexm_dcache_resp
  import aexm_dcache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  aexm_dcache_if.slave      core,
  aexm_dcache_mem_if.master mem
);

  localparam int TAG_W = tagWidth(IDX_W);
  localparam int LINES = 1 << IDX_W;

`ifdef AEXM_DCACHE_WRITE_ALLOC_EN
  localparam bit WRITE_ALLOC = 1'b1;
`else
  localparam bit WRITE_ALLOC = 1'b0;
`endif

  dcState_t stateReg, stateNext;

  logic [IDX_W-1:0] preIdx, cycIdx, wrIdx;
  logic [TAG_W-1:0] cycTag, rdTag, wrTag;
  logic [31:0]      rdData, wrData, dataI;
  logic [LINES-1:0] validReg, lineSet;
  logic             hit, readHit, accept, busyN, ramWrEn;

  logic             memReqReg, memWeReg, storeHitReg;
  logic [29:0]      memAddrReg;
  logic [31:0]      memWdataReg, fillReg;

  logic             unusedAddrBits;
  assign unusedAddrBits = ^{core.aexm_dcache_precycle_addr[31:IDX_W+2],
                            core.aexm_dcache_precycle_addr[1:0],
                            core.aexm_dcache_cycle_addr[1:0]};

  assign preIdx  = core.aexm_dcache_precycle_addr[IDX_W+1:2];
  assign cycIdx  = core.aexm_dcache_cycle_addr[IDX_W+1:2];
  assign cycTag  = core.aexm_dcache_cycle_addr[31:IDX_W+2];

  assign hit     = validReg[cycIdx] && (rdTag == cycTag);
  assign readHit = hit && !core.aexm_dcache_cycle_we;

  // A new access may only start when the current one completes this cycle.
  assign accept  = core.aexm_dcache_precycle_enable &&
                   ((stateReg == IDLE) || (stateReg == REPLAY) ||
                    ((stateReg == LOOK) && readHit));

  assign ramWrEn = mem.mem_ack &&
                   ((stateReg == RDMISS) ||
                    ((stateReg == WRTHRU) && (storeHitReg || WRITE_ALLOC)));
  assign wrIdx   = memAddrReg[IDX_W-1:0];
  assign wrTag   = memAddrReg[29:IDX_W];
  assign wrData  = (stateReg == RDMISS) ? mem.mem_rdata : memWdataReg;

  aexm_dcache_ram #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) uRam (
    .gclk   (sys_clk_i),
    .rdEn   (accept),
    .rdIdx  (preIdx),
    .rdTag  (rdTag),
    .rdData (rdData),
    .wrEn   (ramWrEn),
    .wrIdx  (wrIdx),
    .wrTag  (wrTag),
    .wrData (wrData)
  );

  for (genvar gi = 0; gi < LINES; gi++) begin : gLineSet
    assign lineSet[gi] = ramWrEn && (wrIdx == IDX_W'(gi));
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      stateReg <= IDLE;
      validReg <= '0;
    end else begin
      stateReg <= stateNext;
      validReg <= validReg | lineSet;
    end
  end

  always_comb begin
    stateNext = stateReg;
    busyN     = 1'b1;
    dataI     = '0;
    case (stateReg)
      IDLE: begin
        stateNext = accept ? LOOK : IDLE;
      end
      LOOK: begin
        if (core.aexm_dcache_cycle_we) begin
          busyN     = 1'b0;
          stateNext = WRTHRU;
        end else if (!hit) begin
          busyN     = 1'b0;
          stateNext = RDMISS;
        end else begin
          dataI     = rdData;
          stateNext = accept ? LOOK : IDLE;
        end
      end
      RDMISS, WRTHRU: begin
        busyN = 1'b0;
        if (mem.mem_ack) begin
          stateNext = REPLAY;
        end
      end
      REPLAY: begin
        dataI     = fillReg;
        stateNext = accept ? LOOK : IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Request fields are captured once on leaving LOOK and held until the ack.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      memReqReg   <= 1'b0;
      memWeReg    <= 1'b0;
      memAddrReg  <= '0;
      memWdataReg <= '0;
      storeHitReg <= 1'b0;
      fillReg     <= '0;
    end else begin
      memReqReg <= (stateNext == RDMISS) || (stateNext == WRTHRU);
      if ((stateReg == LOOK) && !readHit) begin
        memWeReg    <= core.aexm_dcache_cycle_we;
        memAddrReg  <= core.aexm_dcache_cycle_addr[31:2];
        memWdataReg <= core.aexm_dcache_datao;
        storeHitReg <= hit;
      end
      if ((stateReg == RDMISS) && mem.mem_ack) begin
        fillReg <= mem.mem_rdata;
      end
    end
  end

  assign core.aexm_dcache_datai        = dataI;
  assign core.aexm_dcache_cache_busy_n = busyN;
  assign mem.mem_req   = memReqReg;
  assign mem.mem_we    = memWeReg;
  assign mem.mem_addr  = memAddrReg;
  assign mem.mem_wdata = memWdataReg;

endmodule

// File: tb/tb_aexm_dcache_resp.sv
// Directed bench for aexm_dcache_resp: a core driver plus a delayed-ack memory model.
module tb_aexm_dcache_resp;

  logic sysClk, sysRst;
  int   total = 0;
  int   bad = 0;

  int          ackDelay = 1;
  bit          ackEnable = 1;
  bit          lateAck = 0;
  int          reqCycles = 0;
  logic [31:0] rdataVal = 32'h0;

  aexm_dcache_if     coreBus ();
  aexm_dcache_mem_if memBus ();

  aexm_dcache_resp dut (
    .sys_clk_i (sysClk),
    .sys_rst_i (sysRst),
    .core      (coreBus),
    .mem       (memBus)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  // Memory model: pulses ack on the ackDelay-th cycle that mem_req is seen high.
  always @(negedge sysClk) begin
    memBus.mem_ack = 1'b0;
    if (lateAck) begin
      memBus.mem_ack   = 1'b1;
      memBus.mem_rdata = 32'h5A5A_5A5A;
      lateAck          = 1'b0;
    end else if (ackEnable && memBus.mem_req === 1'b1) begin
      reqCycles++;
      if (reqCycles >= ackDelay) begin
        memBus.mem_ack   = 1'b1;
        memBus.mem_rdata = rdataVal;
        reqCycles        = 0;
      end
    end else begin
      reqCycles = 0;
    end
  end

  task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        output int stall, output logic [31:0] rd, output bit sawReq,
                        output logic memWe, output logic [29:0] memAddr, output logic [31:0] memWdata);
    stall = 0; sawReq = 0; memWe = 1'b0; memAddr = '0; memWdata = '0;
    @(negedge sysClk);
    coreBus.aexm_dcache_precycle_enable = 1'b1;
    coreBus.aexm_dcache_precycle_addr   = addr;
    @(negedge sysClk);
    coreBus.aexm_dcache_precycle_enable = 1'b0;
    coreBus.aexm_dcache_cycle_addr      = addr;
    coreBus.aexm_dcache_cycle_we        = we;
    coreBus.aexm_dcache_datao           = wdata;
    #1;
    while (coreBus.aexm_dcache_cache_busy_n !== 1'b1 && stall < 50) begin
      stall++;
      @(negedge sysClk);
      #1;
      if (memBus.mem_req === 1'b1) begin
        sawReq = 1; memWe = memBus.mem_we; memAddr = memBus.mem_addr; memWdata = memBus.mem_wdata;
      end
    end
    rd = coreBus.aexm_dcache_datai;
    coreBus.aexm_dcache_cycle_we = 1'b0;
    total++;
    if (stall >= 50) begin
      bad++; $display("FAIL access_timeout addr=%h busy_n stuck low for %0d cycles", addr, stall);
    end
    $display("access addr=%h we=%0d stall=%0d datai=%h req=%0d", addr, we, stall, rd, sawReq);
  endtask

  task automatic test_reset();
    sysRst = 1'b1;
    repeat (3) @(negedge sysClk);
    #1;
    total++; if (coreBus.aexm_dcache_cache_busy_n !== 1'b1) begin bad++; $display("FAIL reset_busy_n got=%b want=1", coreBus.aexm_dcache_cache_busy_n); end
    total++; if (coreBus.aexm_dcache_datai !== 32'h0) begin bad++; $display("FAIL reset_datai got=%h want=0", coreBus.aexm_dcache_datai); end
    total++; if (memBus.mem_req !== 1'b0 || memBus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_req_we got=%b%b want=00", memBus.mem_req, memBus.mem_we); end
    total++; if (memBus.mem_addr !== 30'h0 || memBus.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_addr_wdata got=%h/%h want=0/0", memBus.mem_addr, memBus.mem_wdata); end
    @(negedge sysClk);
    sysRst = 1'b0;
  endtask

  task automatic test_cold_read();
    int st; logic [31:0] rd; bit rq; logic mw; logic [29:0] ma; logic [31:0] md;
    ackDelay = 3; rdataVal = 32'hDEAD_BEEF;
    access(32'h0000_0100, 1'b0, 32'h0, st, rd, rq, mw, ma, md);
    total++; if (st != 4) begin bad++; $display("FAIL cold_stall got=%0d want=4", st); end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cold_data got=%h want=deadbeef", rd); end
    total++; if (!rq || mw !== 1'b0 || ma !== 30'h40) begin bad++; $display("FAIL cold_req got req=%0d we=%b addr=%h want 1/0/40", rq, mw, ma); end
  endtask

  task automatic test_read_hit();
    int st; logic [31:0] rd; bit rq; logic mw; logic [29:0] ma; logic [31:0] md;
    access(32'h0000_0100, 1'b0, 32'h0, st, rd, rq, mw, ma, md);
    total++; if (st != 0 || rq) begin bad++; $display("FAIL hit_stall got stall=%0d req=%0d want 0/0", st, rq); end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hit_data got=%h want=deadbeef", rd); end
  endtask

  task automatic test_store_hit();
    int st; logic [31:0] rd; bit rq; logic mw; logic [29:0] ma; logic [31:0] md;
    ackDelay = 1;
    access(32'h0000_0100, 1'b1, 32'h1234_5678, st, rd, rq, mw, ma, md);
    total++; if (st != 2) begin bad++; $display("FAIL store_stall got=%0d want=2", st); end
    total++; if (!rq || mw !== 1'b1 || ma !== 30'h40 || md !== 32'h1234_5678) begin bad++; $display("FAIL store_req got req=%0d we=%b addr=%h wdata=%h want 1/1/40/12345678", rq, mw, ma, md); end
    access(32'h0000_0100, 1'b0, 32'h0, st, rd, rq, mw, ma, md);
    total++; if (st != 0 || rd !== 32'h1234_5678) begin bad++; $display("FAIL store_readback got stall=%0d data=%h want 0/12345678", st, rd); end
  endtask

  task automatic test_store_miss();
    int st; logic [31:0] rd; bit rq; logic mw; logic [29:0] ma; logic [31:0] md;
    int expStall; logic [31:0] expData; bit expReq;
`ifdef AEXM_DCACHE_WRITE_ALLOC_EN
    expStall = 0; expData = 32'hCAFE_F00D; expReq = 0;
`else
    expStall = 2; expData = 32'h0BAD_F00D; expReq = 1;
`endif
    ackDelay = 1; rdataVal = 32'h0BAD_F00D;
    access(32'h0000_0200, 1'b1, 32'hCAFE_F00D, st, rd, rq, mw, ma, md);
    total++; if (st != 2 || mw !== 1'b1 || ma !== 30'h80) begin bad++; $display("FAIL smiss_store got stall=%0d we=%b addr=%h want 2/1/80", st, mw, ma); end
    access(32'h0000_0200, 1'b0, 32'h0, st, rd, rq, mw, ma, md);
    total++; if (st != expStall || rq != expReq) begin bad++; $display("FAIL smiss_read got stall=%0d req=%0d want %0d/%0d", st, rq, expStall, expReq); end
    total++; if (rd !== expData) begin bad++; $display("FAIL smiss_data got=%h want=%h", rd, expData); end
    total++; if (expReq && mw !== 1'b0) begin bad++; $display("FAIL smiss_we got=%b want=0", mw); end
  endtask

  task automatic test_evict();
    int st; logic [31:0] rd; bit rq; logic mw; logic [29:0] ma; logic [31:0] md;
    ackDelay = 1; rdataVal = 32'h1111_0000;
    access(32'h0001_0100, 1'b0, 32'h0, st, rd, rq, mw, ma, md);
    total++; if (st != 2 || ma !== 30'h4040 || rd !== 32'h1111_0000) begin bad++; $display("FAIL evict_new got stall=%0d addr=%h data=%h want 2/4040/11110000", st, ma, rd); end
    rdataVal = 32'h2222_0000;
    access(32'h0000_0100, 1'b0, 32'h0, st, rd, rq, mw, ma, md);
    total++; if (st != 2 || !rq || rd !== 32'h2222_0000) begin bad++; $display("FAIL evict_old got stall=%0d req=%0d data=%h want 2/1/22220000", st, rq, rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp200;
`ifdef AEXM_DCACHE_WRITE_ALLOC_EN
    exp200 = 32'hCAFE_F00D;
`else
    exp200 = 32'h0BAD_F00D;
`endif
    @(negedge sysClk);
    coreBus.aexm_dcache_precycle_enable = 1'b1;
    coreBus.aexm_dcache_precycle_addr   = 32'h0000_0100;
    @(negedge sysClk);
    coreBus.aexm_dcache_cycle_addr      = 32'h0000_0100;
    coreBus.aexm_dcache_precycle_addr   = 32'h0000_0200;
    #1;
    total++; if (coreBus.aexm_dcache_cache_busy_n !== 1'b1 || coreBus.aexm_dcache_datai !== 32'h2222_0000) begin bad++; $display("FAIL b2b_first got busy_n=%b data=%h want 1/22220000", coreBus.aexm_dcache_cache_busy_n, coreBus.aexm_dcache_datai); end
    $display("access addr=00000100 b2b datai=%h", coreBus.aexm_dcache_datai);
    @(negedge sysClk);
    coreBus.aexm_dcache_precycle_enable = 1'b0;
    coreBus.aexm_dcache_cycle_addr      = 32'h0000_0200;
    #1;
    total++; if (coreBus.aexm_dcache_cache_busy_n !== 1'b1 || coreBus.aexm_dcache_datai !== exp200) begin bad++; $display("FAIL b2b_second got busy_n=%b data=%h want 1/%h", coreBus.aexm_dcache_cache_busy_n, coreBus.aexm_dcache_datai, exp200); end
    $display("access addr=00000200 b2b datai=%h", coreBus.aexm_dcache_datai);
  endtask

  task automatic test_reset_mid();
    int st; logic [31:0] rd; bit rq; logic mw; logic [29:0] ma; logic [31:0] md;
    int waitCnt;
    ackEnable = 0;
    @(negedge sysClk);
    coreBus.aexm_dcache_precycle_enable = 1'b1;
    coreBus.aexm_dcache_precycle_addr   = 32'h0000_0300;
    @(negedge sysClk);
    coreBus.aexm_dcache_precycle_enable = 1'b0;
    coreBus.aexm_dcache_cycle_addr      = 32'h0000_0300;
    waitCnt = 0;
    #1;
    while (memBus.mem_req !== 1'b1 && waitCnt < 10) begin
      waitCnt++; @(negedge sysClk); #1;
    end
    total++; if (memBus.mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_req_rise got=%b want=1", memBus.mem_req); end
    sysRst = 1'b1;
    #1;
    total++; if (memBus.mem_req !== 1'b0 || coreBus.aexm_dcache_cache_busy_n !== 1'b1) begin bad++; $display("FAIL rstmid_async got req=%b busy_n=%b want 0/1", memBus.mem_req, coreBus.aexm_dcache_cache_busy_n); end
    @(negedge sysClk);
    sysRst  = 1'b0;
    lateAck = 1'b1;
    repeat (3) @(negedge sysClk);
    #1;
    total++; if (memBus.mem_req !== 1'b0 || coreBus.aexm_dcache_cache_busy_n !== 1'b1 || coreBus.aexm_dcache_datai !== 32'h0) begin bad++; $display("FAIL rstmid_late_ack got req=%b busy_n=%b datai=%h want 0/1/0", memBus.mem_req, coreBus.aexm_dcache_cache_busy_n, coreBus.aexm_dcache_datai); end
    ackEnable = 1; ackDelay = 1; rdataVal = 32'h3333_0000;
    access(32'h0000_0100, 1'b0, 32'h0, st, rd, rq, mw, ma, md);
    total++; if (st != 2 || !rq || rd !== 32'h3333_0000) begin bad++; $display("FAIL rstmid_invalid got stall=%0d req=%0d data=%h want 2/1/33330000", st, rq, rd); end
  endtask

  initial begin
    sysRst = 1'b1;
    coreBus.aexm_dcache_precycle_addr   = '0;
    coreBus.aexm_dcache_precycle_enable = 1'b0;
    coreBus.aexm_dcache_cycle_addr      = '0;
    coreBus.aexm_dcache_cycle_we        = 1'b0;
    coreBus.aexm_dcache_datao           = '0;
    memBus.mem_ack   = 1'b0;
    memBus.mem_rdata = '0;
    test_reset();
    test_cold_read();
    test_read_hit();
    test_store_hit();
    test_store_miss();
    test_evict();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge sysClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
